// File: rtl/viterbi_ber_checker.sv
// BER sink behind the Viterbi decoder: aligns decoded bits against buffered encoder input bits.
// All outputs registered, 1-cycle latency; no backpressure (overflow drops refs, underrun ignores decodes).
module viterbi_ber_checker #(
   parameter int AW     = 7,
   parameter int SKIP   = 16,
   parameter int WINDOW = 256,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             ref_valid_i,
   input  logic             ref_bit_i,
   input  logic             dec_valid_i,
   input  logic             dec_bit_i,
   output logic [CNT_W-1:0] bit_ct_o,
   output logic [CNT_W-1:0] err_ct_o,
   output logic [15:0]      max_burst_o,
   output logic             mismatch_o,
   output logic             done_o,
   output logic             overflow_o,
   output logic             underrun_o
);

   typedef enum logic [1:0] {S_IDLE, S_SKIP, S_COUNT, S_DONE} state_t;

   localparam int               DEPTH     = 1 << AW;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] WIN       = CNT_W'(WINDOW);
   localparam logic [15:0]      SKIP_LAST = 16'(SKIP - 1);

   state_t           state_q, state_d;
   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH-1:0] mem_q;
   logic [15:0]      skip_ct_q, skip_ct_d;
   logic [15:0]      run_q, run_d;
   logic [15:0]      max_burst_q, max_burst_d;
   logic [CNT_W-1:0] bit_ct_q, bit_ct_d, err_ct_q, err_ct_d;
   logic             mismatch_q, mismatch_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d, unr_q, unr_d;

   logic fifo_empty, fifo_full, pop, push, pop_bit, miss;

   // Pointers carry one extra bit so full and empty are distinguishable when the indices match.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop        = dec_valid_i && !fifo_empty;
   assign push       = ref_valid_i && (!fifo_full || pop);
   assign pop_bit    = mem_q[rd_ptr_q[AW-1:0]];
   assign miss       = pop_bit ^ dec_bit_i;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      skip_ct_d   = skip_ct_q;
      run_d       = run_q;
      max_burst_d = max_burst_q;
      bit_ct_d    = bit_ct_q;
      err_ct_d    = err_ct_q;
      mismatch_d  = 1'b0;
      ovf_d       = ovf_q;
      unr_d       = unr_q;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (ref_valid_i && fifo_full && !pop) ovf_d = 1'b1;
      if (dec_valid_i && fifo_empty)        unr_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (push) state_d = (SKIP == 0) ? S_COUNT : S_SKIP;
         end
         S_SKIP: begin
            if (pop) begin
               skip_ct_d = skip_ct_q + 16'd1;
               if (skip_ct_q == SKIP_LAST) state_d = S_COUNT;
            end
         end
         S_COUNT: begin
            if (pop) begin
               bit_ct_d = (bit_ct_q == CNT_MAX) ? bit_ct_q : bit_ct_q + 1'b1;
               if (miss) begin
                  err_ct_d   = (err_ct_q == CNT_MAX) ? err_ct_q : err_ct_q + 1'b1;
                  run_d      = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
                  mismatch_d = 1'b1;
               end else begin
                  run_d = 16'd0;
               end
               if (run_d > max_burst_q) max_burst_d = run_d;
               if (bit_ct_d == WIN) state_d = S_DONE;
            end
         end
         default: ;
      endcase

      if (clear_i) begin
         state_d     = S_IDLE;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         skip_ct_d   = '0;
         run_d       = '0;
         max_burst_d = '0;
         bit_ct_d    = '0;
         err_ct_d    = '0;
         mismatch_d  = 1'b0;
         ovf_d       = 1'b0;
         unr_d       = 1'b0;
      end

      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         skip_ct_q   <= '0;
         run_q       <= '0;
         max_burst_q <= '0;
         bit_ct_q    <= '0;
         err_ct_q    <= '0;
         mismatch_q  <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
         unr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         skip_ct_q   <= skip_ct_d;
         run_q       <= run_d;
         max_burst_q <= max_burst_d;
         bit_ct_q    <= bit_ct_d;
         err_ct_q    <= err_ct_d;
         mismatch_q  <= mismatch_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
         unr_q       <= unr_d;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= ref_bit_i;
   end

   assign bit_ct_o    = bit_ct_q;
   assign err_ct_o    = err_ct_q;
   assign max_burst_o = max_burst_q;
   assign mismatch_o  = mismatch_q;
   assign done_o      = done_q;
   assign overflow_o  = ovf_q;
   assign underrun_o  = unr_q;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Bench for viterbi_ber_checker: queue-based reference model checked every cycle plus literal scenario results.
module tb_viterbi_ber_checker;
   localparam int AW = 7, SKIP = 16, WINDOW = 256, CNT_W = 32, DEPTH = 128;

   logic clk = 1'b0, rst = 1'b1;
   logic clear_i = 1'b0, rv = 1'b0, rb = 1'b0, dv = 1'b0, db = 1'b0;
   logic [CNT_W-1:0] bit_ct_o, err_ct_o;
   logic [15:0] max_burst_o;
   logic mismatch_o, done_o, overflow_o, underrun_o;

   viterbi_ber_checker #(.AW(AW), .SKIP(SKIP), .WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .clear_i(clear_i),
      .ref_valid_i(rv), .ref_bit_i(rb), .dec_valid_i(dv), .dec_bit_i(db),
      .bit_ct_o(bit_ct_o), .err_ct_o(err_ct_o), .max_burst_o(max_burst_o),
      .mismatch_o(mismatch_o), .done_o(done_o), .overflow_o(overflow_o), .underrun_o(underrun_o)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0, mis_pulses = 0;
   bit cmp_en = 1'b0;
   bit refbits [0:399];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a bit queue for the FIFO and plain counters over the stream of accepted pops.
   bit mq[$];
   int m_pops, m_counted, m_err, m_run, m_max;
   bit m_mis, m_ovf, m_unr, m_pop, m_push, m_pb;

   task automatic model_reset();
      mq.delete();
      m_pops = 0; m_counted = 0; m_err = 0; m_run = 0; m_max = 0;
      m_mis = 0; m_ovf = 0; m_unr = 0;
   endtask

   always @(negedge rst) model_reset();

   always @(posedge clk) begin
      if (rst) begin
         if (clear_i) model_reset();
         else begin
            m_mis  = 0;
            m_pop  = dv && (mq.size() != 0);
            m_push = rv && ((mq.size() != DEPTH) || m_pop);
            if (rv && mq.size() == DEPTH && !m_pop) m_ovf = 1;
            if (dv && mq.size() == 0) m_unr = 1;
            if (m_pop) begin
               m_pb = mq.pop_front();
               m_pops++;
               if (m_pops > SKIP && m_counted < WINDOW) begin
                  m_counted++;
                  if (m_pb != db) begin
                     m_err++; m_run++; m_mis = 1;
                  end else m_run = 0;
                  if (m_run > m_max) m_max = m_run;
               end
            end
            if (m_push) mq.push_back(rb);
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("bit_ct", bit_ct_o, m_counted);
         check("err_ct", err_ct_o, m_err);
         check("max_burst", max_burst_o, m_max);
         check("mismatch", mismatch_o, m_mis);
         check("done", done_o, m_counted == WINDOW);
         check("overflow", overflow_o, m_ovf);
         check("underrun", underrun_o, m_unr);
         if (mismatch_o) mis_pulses++;
      end
   end

   task automatic step(input bit c, input bit r, input bit rbit, input bit d, input bit dbit);
      clear_i = c; rv = r; rb = rbit; dv = d; db = dbit;
      @(posedge clk);
      #2;
   endtask

   task automatic do_clear();
      step(1, 0, 0, 0, 0);
      check("clear_bit_ct", bit_ct_o, 0);
      check("clear_done", done_o, 0);
   endtask

   // mode 0: clean echo; mode 1: every 8th counted bit flipped; mode 2: counted 100..104 and skip bit 5 flipped
   task automatic run_chain(input int mode, input int abort_at);
      bit r, rbit, d, dbit;
      int k, c;
      for (int t = 0; t < 440; t++) begin
         r    = (t < 400);
         rbit = r ? refbits[t] : 1'b0;
         k    = t - 40;
         d    = (k >= 0);
         c    = k - SKIP;
         dbit = d ? refbits[k] : 1'b0;
         if (mode == 1 && c >= 0 && (c % 8) == 7) dbit = ~dbit;
         if (mode == 2 && ((c >= 100 && c <= 104) || k == 5)) dbit = ~dbit;
         step(0, r, rbit, d, dbit);
         if (t == abort_at) begin
            #1 rst = 1'b0;
            #1;
            check("async_rst_bit_ct", bit_ct_o, 0);
            check("async_rst_err_ct", err_ct_o, 0);
            check("async_rst_done", done_o, 0);
            break;
         end
      end
      step(0, 0, 0, 0, 0);
   endtask

   task automatic check_clean_result(input string tag);
      check({tag, "_done"}, done_o, 1);
      check({tag, "_bit_ct"}, bit_ct_o, 256);
      check({tag, "_err_ct"}, err_ct_o, 0);
      check({tag, "_max_burst"}, max_burst_o, 0);
      check({tag, "_ovf"}, overflow_o, 0);
      check({tag, "_unr"}, underrun_o, 0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 400; i++) refbits[i] = ^(i * 13 + 7) ^ i[4];
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("reset_bit_ct", bit_ct_o, 0);
      check("reset_err_ct", err_ct_o, 0);
      check("reset_max_burst", max_burst_o, 0);
      check("reset_flags", {mismatch_o, done_o, overflow_o, underrun_o}, 0);
      rst = 1'b1;
      cmp_en = 1'b1;

      run_chain(0, -1);
      check_clean_result("clean");

      do_clear();
      mis_pulses = 0;
      run_chain(1, -1);
      check("every8_err_ct", err_ct_o, 32);
      check("every8_max_burst", max_burst_o, 1);
      check("every8_pulses", mis_pulses, 32);
      check("every8_bit_ct", bit_ct_o, 256);

      do_clear();
      run_chain(2, -1);
      check("burst5_err_ct", err_ct_o, 5);
      check("burst5_max_burst", max_burst_o, 5);
      check("burst5_bit_ct", bit_ct_o, 256);

      do_clear();
      for (int i = 0; i < 130; i++) begin
         step(0, 1, refbits[i], 0, 0);
         if (i == 127) check("ovf_at_push128", overflow_o, 0);
         if (i == 128) check("ovf_at_push129", overflow_o, 1);
      end
      for (int i = 0; i < 128; i++) step(0, 0, 0, 1, refbits[i]);
      check("drain_err_ct", err_ct_o, 0);
      check("drain_bit_ct", bit_ct_o, 112);
      check("drain_unr", underrun_o, 0);
      step(0, 0, 0, 1, 0);
      check("empty_pop_unr", underrun_o, 1);
      check("empty_pop_bit_ct", bit_ct_o, 112);

      do_clear();
      for (int i = 0; i < 128; i++) step(0, 1, refbits[i], 0, 0);
      for (int j = 0; j < 4; j++) step(0, 1, refbits[128 + j], 1, refbits[j]);
      check("full_pushpop_ovf", overflow_o, 0);
      for (int i = 4; i < 132; i++) step(0, 0, 0, 1, refbits[i]);
      check("full_drain_unr", underrun_o, 0);
      check("full_drain_bit_ct", bit_ct_o, 116);
      check("full_drain_err_ct", err_ct_o, 0);
      step(0, 0, 0, 1, 0);
      check("full_extra_pop_unr", underrun_o, 1);
      step(1, 1, 1, 1, 1);
      check("clear_all_outputs", {bit_ct_o, err_ct_o, max_burst_o, mismatch_o, done_o, overflow_o, underrun_o}, 0);
      step(0, 0, 0, 1, 0);
      check("clear_fifo_empty_unr", underrun_o, 1);
      check("clear_fifo_empty_bit_ct", bit_ct_o, 0);

      do_clear();
      run_chain(0, 150);
      step(0, 0, 0, 0, 0);
      #3 rst = 1'b1;
      step(0, 0, 0, 0, 0);
      run_chain(0, -1);
      check_clean_result("rerun");

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/viterbi_ber_checker.md
Name: viterbi_ber_checker

Overview:
- Sink stage directly downstream of the Viterbi decoder in the tx/rx chain.
- Buffers the original encoder input bits in an alignment FIFO and pops one per valid decoded bit.
- Compares each decoded bit with its buffered original and accumulates bit count, error count and longest error burst over a measurement window.
- Gives a pass/fail bit-error-rate figure for each channel error setting.

Parameters:
AW, 7, log2 of alignment FIFO depth (depth 2**AW = 128 reference bits)
SKIP, 16, decoded bits discarded after start (decoder warm-up/traceback flush); legal range 0..65535
WINDOW, 256, number of compared bits per measurement; must be >= 1
CNT_W, 32, width of bit/error counters

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
clear_i  input  1  synchronous restart of measurement
ref_valid_i  input  1  reference bit present (encoder input enable)
ref_bit_i  input  1  reference bit (encoder input)
dec_valid_i  input  1  decoded bit present
dec_bit_i  input  1  decoded bit
bit_ct_o  output  CNT_W  bits compared in COUNT
err_ct_o  output  CNT_W  mismatches in COUNT
max_burst_o  output  16  longest run of consecutive mismatches
mismatch_o  output  1  one-cycle pulse per counted mismatch
done_o  output  1  high while in DONE
overflow_o  output  1  sticky: reference bit dropped, FIFO full
underrun_o  output  1  sticky: decoded bit arrived with FIFO empty

Behaviour:
- Reset (rst low, asynchronous): FIFO empty, state IDLE, all outputs 0, internal run length and skip counter 0.
- clear_i (synchronous): same effect as reset. Highest priority; push/pop/compare ignored in that cycle.
- FIFO push: when ref_valid_i=1 and FIFO not full; push is allowed in every state except after clear in the same cycle.
- FIFO full and ref_valid_i=1 without a pop that cycle: bit dropped, overflow_o<=1.
- Push and pop together on a full FIFO are both accepted.
- FIFO pop: when dec_valid_i=1 and FIFO not empty (occupancy at start of cycle). The popped bit is compared with dec_bit_i.
- Empty FIFO and dec_valid_i=1: no pop, no compare, underrun_o<=1. This holds even if a push happens that cycle.
- State machine:
  - IDLE: moves to SKIP on the first accepted push; moves directly to COUNT if SKIP=0.
  - SKIP: each pop increments the skip counter, no comparison counted. After the SKIP-th pop, go to COUNT.
  - COUNT: each pop increments bit_ct_o.
    - Mismatch: increments err_ct_o and the run length, and pulses mismatch_o.
    - Match: resets the run length to 0.
    - max_burst_o <= max(max_burst_o, new run length), evaluated every counted pop.
    - When bit_ct_o reaches WINDOW (the pop making it WINDOW), go to DONE.
  - DONE: counters and max_burst_o frozen. Pops continue, keeping the FIFO draining, but are not counted; mismatch_o stays 0. done_o=1. Leave only by clear_i or reset.
- Timing: all outputs registered.
  - mismatch_o, bit_ct_o and err_ct_o reflect a dec_valid_i sample on the next rising edge (1-cycle latency).
  - done_o rises in the same cycle that bit_ct_o shows WINDOW.
- Arithmetic:
  - Counters saturate at all-ones.
  - Run length and max_burst_o saturate at 16'hFFFF.
  - FIFO pointers are AW+1 bits; wrap-around is natural binary wrap.
- Overflow and underrun are sticky in all states until reset/clear. They do not stop counting.

Test Plan:
- Error-free chain, SKIP=16, WINDOW=256; 400 reference bits in, decoder echoes them after 40 cycles -> done_o=1, bit_ct_o=256, err_ct_o=0, max_burst_o=0, no sticky flags.
- Decoded bit inverted every 8th counted bit -> err_ct_o=32, max_burst_o=1, 32 mismatch_o pulses, each one cycle after the corrupted dec_valid_i.
- Counted bits 100..104 inverted -> err_ct_o=5, max_burst_o=5; mismatches in the SKIP region are not counted.
- 130 pushes with no pops -> overflow_o=1 at push 129. Then 128 pops reproduce the first 128 bits exactly. Next dec_valid_i on the empty FIFO -> underrun_o=1, bit_ct_o unchanged.
- Simultaneous push/pop with FIFO full -> no overflow, occupancy stays 128. clear_i asserted together with ref_valid_i and dec_valid_i -> all outputs 0 next cycle, FIFO empty, state IDLE.
- rst pulsed low mid-COUNT, asynchronously between edges -> outputs 0 immediately. Rerun of the first scenario gives identical results.
